driver_sequencer: RTL and testbench

Frame sequencer for the LED driver chain: walks the multiplexed rows and, within each row, the driver channels. It fetches one grayscale word per channel from the upstream frame buffer through a request/valid handshake. Each word is serialised MSB-first onto the driver data line with a matching shift-clock enable. The sequencer generates the latch pulses whose width encodes the driver command: 1 bit = write-GS, 3 bits = latch-GS. It sits between the voxel/frame buffer read side and the driver output pins, and replaces free-running pass-through of voxel data.

---
 rtl/driver_sequencer.sv | 143 ++++++++++++++
 tb/tb_driver_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_sequencer.sv
// driver_sequencer: frame sequencer for the LED driver chain.
// Walks MULTIPLEXING rows x CHANNELS channels. For each channel it fetches one
// BITS-wide grayscale word through a req/valid handshake. The word is then
// shifted out MSB-first with a matching shift-clock enable. Latch pulses are
// generated alongside: 1 bit wide = write-GS, 3 bits wide on the last channel
// of a row = latch-GS.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle frame start request, honoured only when idle
//   busy        high while a frame is in progress
//   data_req    request for the next grayscale word
//   data_valid  upstream word available on data_in
//   data_in     grayscale word for the current (row, channel)
//   sout        serial grayscale data
//   sclk_en     high in every cycle sout carries a valid bit
//   lat         driver latch line
//   row         row currently being loaded
//   frame_done  one-cycle pulse after the final bit of a frame
module driver_sequencer #(
    parameter int unsigned MULTIPLEXING = 8,
    parameter int unsigned CHANNELS     = 48,
    parameter int unsigned BITS         = 16,
    localparam int unsigned RW = (MULTIPLEXING > 1) ? $clog2(MULTIPLEXING) : 1,
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned BW = $clog2(BITS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            data_req,
    input  logic            data_valid,
    input  logic [BITS-1:0] data_in,
    output logic            sout,
    output logic            sclk_en,
    output logic            lat,
    output logic [RW-1:0]   row,
    output logic            frame_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [1:0]      state_q, state_n;
    logic [RW-1:0]   row_n;
    logic [CW-1:0]   chan_q, chan_n;
    logic [BW-1:0]   bit_q, bit_n;
    logic [BITS-1:0] shreg_q, shreg_n;
    logic            done_n;
    logic            lat_n;

    // Next-state, counters and shift register.
    always_comb begin
        state_n = state_q;
        row_n   = row;
        chan_n  = chan_q;
        bit_n   = bit_q;
        shreg_n = shreg_q;
        done_n  = 1'b0;
        lat_n   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    row_n   = '0;
                    chan_n  = '0;
                end
            end
            FETCH: begin
                // data_req is high for the whole of FETCH, so valid alone completes the handshake
                if (data_valid) begin
                    shreg_n = data_in;
                    bit_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                shreg_n = {shreg_q[BITS-2:0], 1'b0};
                if (bit_q == BW'(BITS - 1)) begin
                    if (chan_q != CW'(CHANNELS - 1)) begin
                        chan_n  = chan_q + CW'(1);
                        state_n = FETCH;
                    end else if (row != RW'(MULTIPLEXING - 1)) begin
                        row_n   = row + RW'(1);
                        chan_n  = '0;
                        state_n = FETCH;
                    end else begin
                        row_n   = '0;
                        chan_n  = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    bit_n = bit_q + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Latch width encodes the command: last channel of a row gets the 3-bit latch-GS
        if (state_n == SHIFT) begin
            if (chan_n == CW'(CHANNELS - 1)) begin
                lat_n = (bit_n >= BW'(BITS - 3));
            end else begin
                lat_n = (bit_n == BW'(BITS - 1));
            end
        end
    end

    // State, datapath and registered outputs (outputs follow the next state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row        <= '0;
            chan_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            busy       <= 1'b0;
            data_req   <= 1'b0;
            sout       <= 1'b0;
            sclk_en    <= 1'b0;
            lat        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            row        <= row_n;
            chan_q     <= chan_n;
            bit_q      <= bit_n;
            shreg_q    <= shreg_n;
            busy       <= (state_n != IDLE);
            data_req   <= (state_n == FETCH);
            sout       <= (state_n == SHIFT) && shreg_n[BITS-1];
            sclk_en    <= (state_n == SHIFT);
            lat        <= lat_n;
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_driver_sequencer.sv
// Bench for driver_sequencer: a small instance (2 rows, 2 channels, 4 bits)
// driven by a randomized upstream model with a scoreboard, plus a default-size
// instance run through one zero-wait frame.
module tb_driver_sequencer;

    localparam int MUX  = 2;
    localparam int CH   = 2;
    localparam int BITS = 4;
    localparam int NW   = MUX * CH;

    typedef struct packed {
        logic        s;
        logic        l;
        logic [31:0] r;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            data_valid;
    logic [BITS-1:0] data_in;
    logic            busy, data_req, sout, sclk_en, lat, frame_done;
    logic [0:0]      row;

    logic            d_start;
    logic [15:0]     d_data;
    logic            d_busy, d_req, d_sout, d_sclk, d_lat, d_done;
    logic [2:0]      d_row;

    always #5 clk = ~clk;

    driver_sequencer #(.MULTIPLEXING(MUX), .CHANNELS(CH), .BITS(BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .data_req(data_req),
        .data_valid(data_valid), .data_in(data_in), .sout(sout), .sclk_en(sclk_en),
        .lat(lat), .row(row), .frame_done(frame_done)
    );

    driver_sequencer u_dflt (
        .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .data_req(d_req),
        .data_valid(1'b1), .data_in(d_data), .sout(d_sout), .sclk_en(d_sclk),
        .lat(d_lat), .row(d_row), .frame_done(d_done)
    );

    int   checks = 0;
    int   errors = 0;
    int   frames_exp = 0;
    int   frames_seen = 0;
    int   busy_cnt = 0;
    exp_t bitq[$];
    int   lenq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, data_req, sout, sclk_en, lat, row, frame_done});
    endfunction

    // Monitor: pops one expected bit per sclk_en cycle, checks frame length at frame_done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (sclk_en) begin
                    if (bitq.size() == 0) begin
                        chk("unexpected_bit", 1, 0);
                    end else begin
                        e = bitq.pop_front();
                        chk("sout", 32'(sout), 32'(e.s));
                        chk("lat", 32'(lat), 32'(e.l));
                        chk("row_shift", 32'(row), e.r);
                    end
                end else begin
                    chk("lat_without_sclk", 32'(lat), 0);
                end
                if (busy) busy_cnt++;
                if (frame_done) begin
                    frames_seen++;
                    chk("done_busy", 32'(busy), 0);
                    if (lenq.size() == 0) chk("unexpected_done", 1, 0);
                    else chk("busy_len", 32'(busy_cnt), 32'(lenq.pop_front()));
                    chk("bits_left", 32'(bitq.size()), 0);
                    busy_cnt = 0;
                end
            end
        end
    end

    // Upstream model for one word n of a frame: wait for data_req, hold off d cycles,
    // present w, push its expected bit stream, then follow the shift and bubble cycles.
    task automatic drive_word(input int n, input int d, input logic [BITS-1:0] w,
                              input bit last, input int abort_k);
        int   t;
        int   c;
        exp_t e;
        t = 0;
        while (data_req !== 1'b1 && t < 50) begin
            data_valid = 1'($urandom_range(0, 1));
            data_in    = BITS'($urandom);
            @(negedge clk);
            t++;
        end
        chk("req_timeout", 32'(data_req), 1);
        if (data_req !== 1'b1) return;
        chk("row_fetch", 32'(row), 32'(n / CH));
        chk("sclk_in_fetch", 32'(sclk_en), 0);
        data_valid = 1'b0;
        repeat (d) begin
            @(negedge clk);
            chk("req_hold", 32'(data_req), 1);
            chk("sclk_wait", 32'(sclk_en), 0);
        end
        data_valid = 1'b1;
        data_in    = w;
        c = n % CH;
        for (int k = 0; k < BITS; k++) begin
            e.s = w[BITS-1-k];
            e.l = (c == CH - 1) ? (k >= BITS - 3) : (k == BITS - 1);
            e.r = 32'(n / CH);
            bitq.push_back(e);
        end
        for (int k = 0; k < BITS; k++) begin
            @(negedge clk);
            data_valid = 1'($urandom_range(0, 1));
            data_in    = BITS'($urandom);
            chk("sclk_shift", 32'(sclk_en), 1);
            chk("req_shift", 32'(data_req), 0);
            if (k == abort_k) begin
                #1 rst = 1'b1;
                bitq.delete();
                #1 chk("rst_outputs", all_outs(), 0);
                return;
            end
        end
        @(negedge clk);
        data_valid = 1'b0;
        chk("bubble_sclk", 32'(sclk_en), 0);
        chk("bubble_req", 32'(data_req), last ? 0 : 1);
        chk("bubble_done", 32'(frame_done), last ? 1 : 0);
    endtask

    // One frame; caller sets start=1 at a negedge first. dmode<0 picks random delays.
    task automatic run_frame(input int dmode, input bit fixed, input bit chain,
                             input int abort_word, input int abort_k);
        int              d[NW];
        logic [BITS-1:0] w[NW];
        logic [BITS-1:0] fw[NW];
        int              len;
        fw  = '{4'hA, 4'h5, 4'hF, 4'h0};
        len = 0;
        for (int i = 0; i < NW; i++) begin
            d[i] = (dmode < 0) ? int'($urandom_range(0, 3)) : dmode;
            w[i] = fixed ? fw[i] : BITS'($urandom);
            len += BITS + 1 + d[i];
        end
        if (abort_word < 0) begin
            lenq.push_back(len);
            frames_exp++;
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", 32'(busy), 1);
        chk("req_start", 32'(data_req), 1);
        for (int i = 0; i < NW; i++) begin
            drive_word(i, d[i], w[i], i == NW - 1, (i == abort_word) ? abort_k : -1);
            if (i == abort_word) return;
        end
        if (chain) start = 1'b1;
    endtask

    task automatic idle_gap();
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_row", 32'(row), 0);
        chk("idle_req", 32'(data_req), 0);
    endtask

    // Default-size frame, zero wait, data_in = channel index.
    task automatic run_default();
        int          hs, cyc, busy_c, run, gs1, gs3, bad, nbits, words;
        logic [15:0] sh;
        bit          done;
        hs = 0; cyc = 0; busy_c = 0; run = 0; gs1 = 0; gs3 = 0; bad = 0;
        nbits = 0; words = 0; sh = '0; done = 1'b0;
        d_data  = '0;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        while (!done && cyc < 8000) begin
            if (d_busy) busy_c++;
            if (d_lat) begin
                run++;
                if (!d_sclk) bad++;
            end else if (run > 0) begin
                if (run == 3) gs3++;
                else if (run == 1) gs1++;
                else bad++;
                run = 0;
            end
            if (d_sclk) begin
                sh = {sh[14:0], d_sout};
                nbits++;
                if (nbits == 16) begin
                    chk("dflt_word", 32'(sh), 32'(words % 48));
                    words++;
                    nbits = 0;
                end
            end
            if (d_done) done = 1'b1;
            if (d_req) begin
                d_data = 16'(hs % 48);
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("dflt_done_seen", 32'(done), 1);
        chk("dflt_busy_cycles", 32'(busy_c), 6528);
        chk("dflt_latch_gs", 32'(gs3), 8);
        chk("dflt_write_gs", 32'(gs1), 376);
        chk("dflt_bad_lat", 32'(bad), 0);
        chk("dflt_words", 32'(words), 384);
        chk("dflt_handshakes", 32'(hs), 384);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = '0;
        d_start = 1'b0; d_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_outputs", all_outs(), 0);

        // Fixed words, zero wait
        start = 1'b1; run_frame(0, 1'b1, 1'b0, -1, -1); idle_gap();
        // Fixed words, 3-cycle backpressure on every word
        start = 1'b1; run_frame(3, 1'b1, 1'b0, -1, -1); idle_gap();
        // start pulsed mid-frame is ignored
        start = 1'b1;
        fork
            run_frame(-1, 1'b0, 1'b0, -1, -1);
            begin
                repeat (7) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        idle_gap();
        // rst during bit 2 of word 1, then a fresh frame from row 0 / word 0
        start = 1'b1; run_frame(0, 1'b1, 1'b0, 1, 2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", all_outs(), 0);
        start = 1'b1; run_frame(0, 1'b1, 1'b0, -1, -1); idle_gap();
        // start in the frame_done cycle
        start = 1'b1; run_frame(-1, 1'b0, 1'b1, -1, -1);
        run_frame(-1, 1'b0, 1'b0, -1, -1); idle_gap();
        // Random frames, some chained
        repeat (3) begin
            start = 1'b1; run_frame(-1, 1'b0, 1'($urandom_range(0, 1)), -1, -1);
        end
        start = 1'b1; run_frame(-1, 1'b0, 1'b0, -1, -1); idle_gap();

        run_default();

        repeat (2) @(negedge clk);
        chk("frame_count", 32'(frames_seen), 32'(frames_exp));
        chk("queue_empty", 32'(bitq.size()), 0);
        chk("len_queue_empty", 32'(lenq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
